// File: rtl/scb_pkg.sv
// rtl/scb_pkg.sv - shared widths, candidate field layout and retire entry type for the scoreboard retire unit
// Contents:
//   W_ident, W_pip, W_PA_rx : ident / pipe tag / physical register widths
//   UNUSED_CD               : all-ones "no cell" ident
//   READY_BIT, PIP_LSB, RD_LSB, CAND_W : layout of one per-cell completion candidate {ready, pip, rd}
//   retire_entry_t          : one retire FIFO entry {pip, rd}
package scb_pkg;

    localparam int W_ident = 4;
    localparam int W_pip   = 2;
    localparam int W_PA_rx = 5;

    localparam logic [W_ident-1:0] UNUSED_CD = '1;

    localparam int RD_LSB    = 0;
    localparam int PIP_LSB   = W_PA_rx;
    localparam int READY_BIT = W_PA_rx + W_pip;
    localparam int CAND_W    = 1 + W_pip + W_PA_rx;

    typedef struct packed {
        logic [W_pip-1:0]   pip;
        logic [W_PA_rx-1:0] rd;
    } retire_entry_t;

endpackage

// File: rtl/scb_retire_unit_if.sv
// rtl/scb_retire_unit_if.sv - writeback valid/ready port from the retire unit to the register file
// Signals:
//   wb_valid : head entry available (master -> slave)
//   wb_ready : register-file port accepts (slave -> master)
//   wb_pip   : pipe tag of head entry
//   wb_rd    : destination register of head entry
// Modports: master (retire unit side), slave (register-file side)
interface scb_retire_unit_if;
    import scb_pkg::*;

    logic               wb_valid;
    logic               wb_ready;
    logic [W_pip-1:0]   wb_pip;
    logic [W_PA_rx-1:0] wb_rd;

    modport master (output wb_valid, output wb_pip, output wb_rd, input wb_ready);
    modport slave  (input wb_valid, input wb_pip, input wb_rd, output wb_ready);

endinterface

// File: rtl/scb_retire_fifo.sv
// rtl/scb_retire_fifo.sv - in-order retire FIFO, 0..MAX_CAPT pushes and one pop per cycle
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   flush       : empty the FIFO at this edge (overrides push and pop)
//   pop         : remove the head entry
//   push_cnt    : number of push_data slots to append this edge (caller guarantees space)
//   push_data   : entries to append, slot 0 first
//   head        : entry at the read pointer
//   count       : occupancy 0..FIFO_DEPTH
module scb_retire_fifo
    import scb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CAPT   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          pop,
    input  logic [$clog2(FIFO_DEPTH):0]   push_cnt,
    input  retire_entry_t                 push_data [MAX_CAPT],
    output retire_entry_t                 head,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    retire_entry_t mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Depth is a power of two, so pointer arithmetic wraps on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + push_cnt[PW-1:0];
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + push_cnt - CW'(pop);
        end
    end

    // Storage needs no reset: count alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int j = 0; j < MAX_CAPT; j++) begin
                if (CW'(j) < push_cnt)
                    mem[wr_ptr + PW'(j)] <= push_data[j];
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/scb_retire_unit.sv
// rtl/scb_retire_unit.sv - scoreboard retire unit: insert-address select, capture of ready cells, in-order writeback
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   cand_wb_bus   : per-cell completion candidates {ready, pip, rd}, cell k in slice k
//   cand_ins_bus  : per-cell insert candidates (own ident if free, else all-ones)
//   ins_req       : issue stage requests an allocation
//   CFI_PC_clear  : control-flow flush
//   addr_insert   : ident of the cell to allocate, all-ones when none
//   ins_stall     : allocation request cannot be granted
//   wb            : writeback port (master modport)
//   fifo_count    : retire FIFO occupancy
//   retire_ovf    : sticky, a ready candidate was dropped
// Build option: SCB_RD_ZERO_FILTER_EN - ready candidates with rd==0 retire without a FIFO push.
module scb_retire_unit
    import scb_pkg::*;
#(
    parameter int N_CELL     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_CAPT   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CELL*CAND_W-1:0]      cand_wb_bus,
    input  logic [N_CELL*W_ident-1:0]     cand_ins_bus,
    input  logic                          ins_req,
    input  logic                          CFI_PC_clear,
    output logic [W_ident-1:0]            addr_insert,
    output logic                          ins_stall,
    scb_retire_unit_if.master             wb,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          retire_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [W_ident-1:0] min_id;
    logic               full;
    logic               pop;
    logic [CW-1:0]      count;
    logic [CW-1:0]      free_slots;
    logic [CW-1:0]      limit;
    logic [CW-1:0]      n_sel;
    logic [CW-1:0]      push_cnt;
    logic               drop;
    logic               cell_rdy;
    retire_entry_t      cell_ent;
    retire_entry_t      sel_data [MAX_CAPT];
    retire_entry_t      head;

    // Lowest free ident wins; busy cells present all-ones and never win.
    always_comb begin
        min_id = UNUSED_CD;
        for (int k = 0; k < N_CELL; k++) begin
            if (cand_ins_bus[k*W_ident +: W_ident] < min_id)
                min_id = cand_ins_bus[k*W_ident +: W_ident];
        end
    end

    assign full        = (count == CW'(FIFO_DEPTH));
    assign addr_insert = (ins_req && !full && !CFI_PC_clear) ? min_id : UNUSED_CD;
    assign ins_stall   = ins_req & ((min_id == UNUSED_CD) | full | CFI_PC_clear);

    assign wb.wb_valid = (count != '0);
    assign pop         = wb.wb_valid & wb.wb_ready & ~CFI_PC_clear;

    // A same-cycle pop frees its slot for this cycle's pushes.
    assign free_slots = CW'(FIFO_DEPTH) - count + CW'(pop);
    assign limit      = (free_slots < CW'(MAX_CAPT)) ? free_slots : CW'(MAX_CAPT);

    // Scan from cell 0 upward so the lowest index lands in the lowest slot.
    always_comb begin
        n_sel    = '0;
        drop     = 1'b0;
        cell_rdy = 1'b0;
        cell_ent = '0;
        for (int j = 0; j < MAX_CAPT; j++)
            sel_data[j] = '0;
        for (int k = 0; k < N_CELL; k++) begin
            cell_rdy     = cand_wb_bus[k*CAND_W + READY_BIT];
            cell_ent.pip = cand_wb_bus[k*CAND_W + PIP_LSB +: W_pip];
            cell_ent.rd  = cand_wb_bus[k*CAND_W + RD_LSB +: W_PA_rx];
`ifdef SCB_RD_ZERO_FILTER_EN
            // rd==0 has no architectural effect: retire it silently.
            cell_rdy = cell_rdy && (cell_ent.rd != '0);
`endif
            if (cell_rdy) begin
                if (n_sel < limit) begin
                    for (int j = 0; j < MAX_CAPT; j++) begin
                        if (n_sel == CW'(j))
                            sel_data[j] = cell_ent;
                    end
                    n_sel = n_sel + 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    assign push_cnt = CFI_PC_clear ? '0 : n_sel;

    scb_retire_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_CAPT   (MAX_CAPT)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (CFI_PC_clear),
        .pop       (pop),
        .push_cnt  (push_cnt),
        .push_data (sel_data),
        .head      (head),
        .count     (count)
    );

    // A flush cycle captures nothing, so nothing counts as dropped then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_ovf <= 1'b0;
        else if (drop && !CFI_PC_clear)
            retire_ovf <= 1'b1;
    end

    assign wb.wb_pip  = head.pip;
    assign wb.wb_rd   = head.rd;
    assign fifo_count = count;

endmodule

// File: tb/tb_scb_retire_unit.sv
// tb/tb_scb_retire_unit.sv - self-checking bench for scb_retire_unit with a queue-based reference model
module tb_scb_retire_unit;
    import scb_pkg::*;

    localparam int N_CELL     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_CAPT   = 2;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic                      clk;
    logic                      rst_n;
    logic [N_CELL*CAND_W-1:0]  cand_wb_bus;
    logic [N_CELL*W_ident-1:0] cand_ins_bus;
    logic                      ins_req;
    logic                      CFI_PC_clear;
    logic [W_ident-1:0]        addr_insert;
    logic                      ins_stall;
    logic [CW-1:0]             fifo_count;
    logic                      retire_ovf;

    scb_retire_unit_if wb_if ();

    scb_retire_unit #(
        .N_CELL     (N_CELL),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_CAPT   (MAX_CAPT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cand_wb_bus  (cand_wb_bus),
        .cand_ins_bus (cand_ins_bus),
        .ins_req      (ins_req),
        .CFI_PC_clear (CFI_PC_clear),
        .addr_insert  (addr_insert),
        .ins_stall    (ins_stall),
        .wb           (wb_if.master),
        .fifo_count   (fifo_count),
        .retire_ovf   (retire_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of retired entries plus the sticky overflow flag.
    retire_entry_t q[$];
    bit            m_ovf;

    task automatic model_edge();
        int            taken;
        bit            r;
        retire_entry_t e;
        if (!rst_n) return;
        if (CFI_PC_clear) begin
            q.delete();
            return;
        end
        if (q.size() > 0 && wb_if.wb_ready) void'(q.pop_front());
        taken = 0;
        for (int k = 0; k < N_CELL; k++) begin
            r     = cand_wb_bus[k*CAND_W + READY_BIT];
            e.pip = cand_wb_bus[k*CAND_W + PIP_LSB +: W_pip];
            e.rd  = cand_wb_bus[k*CAND_W + RD_LSB +: W_PA_rx];
`ifdef SCB_RD_ZERO_FILTER_EN
            if (e.rd == 0) r = 0;
`endif
            if (r) begin
                if (taken < MAX_CAPT && q.size() < FIFO_DEPTH) begin
                    q.push_back(e);
                    taken++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    function automatic logic [W_ident-1:0] lowest_free();
        logic [W_ident-1:0] m;
        m = '1;
        for (int k = 0; k < N_CELL; k++)
            if (cand_ins_bus[k*W_ident +: W_ident] < m) m = cand_ins_bus[k*W_ident +: W_ident];
        return m;
    endfunction

    function automatic logic [W_ident-1:0] exp_addr();
        if (!ins_req || q.size() == FIFO_DEPTH || CFI_PC_clear) return '1;
        return lowest_free();
    endfunction

    function automatic logic exp_stall();
        return ins_req && (lowest_free() == 4'hF || q.size() == FIFO_DEPTH || CFI_PC_clear);
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cands();
        cand_wb_bus = '0;
    endtask

    task automatic set_cell(input int k, input logic [W_pip-1:0] pip, input logic [W_PA_rx-1:0] rd);
        cand_wb_bus[k*CAND_W +: CAND_W] = {1'b1, pip, rd};
    endtask

    task automatic set_free(input logic [N_CELL-1:0] free_mask);
        for (int k = 0; k < N_CELL; k++)
            cand_ins_bus[k*W_ident +: W_ident] = free_mask[k] ? W_ident'(k) : 4'hF;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        cand_wb_bus     = '0;
        ins_req         = 1'b0;
        CFI_PC_clear    = 1'b0;
        wb_if.wb_ready  = 1'b0;
        set_free('0);
        q.delete();
        m_ovf = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (wb_if.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", wb_if.wb_valid); end
        n_cmp++; if (fifo_count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        n_cmp++; if (retire_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b exp=0", retire_ovf); end
    endtask

    task automatic test_alloc();
        do_reset();
        ins_req = 1'b1;
        set_free(8'hFF); #1;
        n_cmp++; if (addr_insert !== 4'h0) begin n_err++; $display("FAIL alloc_all_free got=%0h exp=0", addr_insert); end
        n_cmp++; if (ins_stall !== 1'b0) begin n_err++; $display("FAIL alloc_all_free_stall got=%0b exp=0", ins_stall); end
        set_free(8'hFC); #1;
        n_cmp++; if (addr_insert !== 4'h2) begin n_err++; $display("FAIL alloc_01_busy got=%0h exp=2", addr_insert); end
        set_free(8'h00); #1;
        n_cmp++; if (addr_insert !== 4'hF) begin n_err++; $display("FAIL alloc_all_busy got=%0h exp=f", addr_insert); end
        n_cmp++; if (ins_stall !== 1'b1) begin n_err++; $display("FAIL alloc_all_busy_stall got=%0b exp=1", ins_stall); end
        set_free(8'hF0); CFI_PC_clear = 1'b1; #1;
        n_cmp++; if (addr_insert !== 4'hF || ins_stall !== 1'b1) begin n_err++; $display("FAIL alloc_clear got=%0h/%0b exp=f/1", addr_insert, ins_stall); end
        CFI_PC_clear = 1'b0; ins_req = 1'b0; #1;
        n_cmp++; if (addr_insert !== 4'hF || ins_stall !== 1'b0) begin n_err++; $display("FAIL alloc_no_req got=%0h/%0b exp=f/0", addr_insert, ins_stall); end
    endtask

    task automatic test_single();
        do_reset();
        wb_if.wb_ready = 1'b1;
        set_cell(3, 2'd2, 5'd9);
        tick();
        clr_cands();
        n_cmp++; if (wb_if.wb_valid !== 1'b1 || wb_if.wb_pip !== 2'd2 || wb_if.wb_rd !== 5'd9)
            begin n_err++; $display("FAIL single_wb got=%0b/%0d/%0d exp=1/2/9", wb_if.wb_valid, wb_if.wb_pip, wb_if.wb_rd); end
        tick();
        n_cmp++; if (wb_if.wb_valid !== 1'b0) begin n_err++; $display("FAIL single_drained got=%0b exp=0", wb_if.wb_valid); end
    endtask

    task automatic test_multi_capture();
        do_reset();
        set_cell(1, 2'd1, 5'd3);
        set_cell(5, 2'd2, 5'd17);
        set_cell(6, 2'd3, 5'd20);
        tick();
        clr_cands();
        n_cmp++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL multi_count got=%0d exp=2", fifo_count); end
        n_cmp++; if (retire_ovf !== 1'b1) begin n_err++; $display("FAIL multi_ovf got=%0b exp=1", retire_ovf); end
        n_cmp++; if (wb_if.wb_pip !== 2'd1 || wb_if.wb_rd !== 5'd3) begin n_err++; $display("FAIL multi_head0 got=%0d/%0d exp=1/3", wb_if.wb_pip, wb_if.wb_rd); end
        wb_if.wb_ready = 1'b1;
        tick();
        n_cmp++; if (wb_if.wb_pip !== 2'd2 || wb_if.wb_rd !== 5'd17) begin n_err++; $display("FAIL multi_head1 got=%0d/%0d exp=2/17", wb_if.wb_pip, wb_if.wb_rd); end
        tick();
        n_cmp++; if (retire_ovf !== 1'b1 || fifo_count !== 3'd0) begin n_err++; $display("FAIL multi_sticky got=%0b/%0d exp=1/0", retire_ovf, fifo_count); end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        set_cell(0, 2'd0, 5'd10);
        set_cell(2, 2'd1, 5'd11);
        tick();
        clr_cands();
        set_cell(4, 2'd2, 5'd12);
        set_cell(7, 2'd3, 5'd13);
        tick();
        clr_cands();
        ins_req = 1'b1; set_free(8'hFF); #1;
        n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
        n_cmp++; if (ins_stall !== 1'b1 || addr_insert !== 4'hF) begin n_err++; $display("FAIL full_stall got=%0b/%0h exp=1/f", ins_stall, addr_insert); end
        tick();
        n_cmp++; if (wb_if.wb_pip !== 2'd0 || wb_if.wb_rd !== 5'd10) begin n_err++; $display("FAIL full_head_stable got=%0d/%0d exp=0/10", wb_if.wb_pip, wb_if.wb_rd); end
        ins_req = 1'b0;
        wb_if.wb_ready = 1'b1;
        set_cell(1, 2'd1, 5'd14);
        tick();
        clr_cands();
        wb_if.wb_ready = 1'b0;
        n_cmp++; if (fifo_count !== 3'd4 || retire_ovf !== 1'b0) begin n_err++; $display("FAIL full_pop_push got=%0d/%0b exp=4/0", fifo_count, retire_ovf); end
        n_cmp++; if (wb_if.wb_rd !== 5'd11) begin n_err++; $display("FAIL full_new_head got=%0d exp=11", wb_if.wb_rd); end
    endtask

    task automatic test_flush();
        do_reset();
        set_cell(0, 2'd1, 5'd1);
        set_cell(1, 2'd1, 5'd2);
        tick();
        clr_cands();
        set_cell(3, 2'd2, 5'd3);
        tick();
        n_cmp++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got=%0d exp=3", fifo_count); end
        CFI_PC_clear = 1'b1;
        wb_if.wb_ready = 1'b1;
        set_cell(5, 2'd3, 5'd4);
        tick();
        CFI_PC_clear = 1'b0;
        clr_cands();
        n_cmp++; if (fifo_count !== 3'd0 || wb_if.wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_empty got=%0d/%0b exp=0/0", fifo_count, wb_if.wb_valid); end
        n_cmp++; if (retire_ovf !== 1'b0) begin n_err++; $display("FAIL flush_ovf got=%0b exp=0", retire_ovf); end
        tick();
        n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL flush_no_capture got=%0d exp=0", fifo_count); end
    endtask

    task automatic test_rd_zero();
        do_reset();
        set_cell(2, 2'd1, 5'd0);
        tick();
        clr_cands();
`ifdef SCB_RD_ZERO_FILTER_EN
        n_cmp++; if (fifo_count !== 3'd0 || wb_if.wb_valid !== 1'b0) begin n_err++; $display("FAIL rd0_filtered got=%0d/%0b exp=0/0", fifo_count, wb_if.wb_valid); end
`else
        n_cmp++; if (fifo_count !== 3'd1 || wb_if.wb_valid !== 1'b1 || wb_if.wb_rd !== 5'd0)
            begin n_err++; $display("FAIL rd0_written got=%0d/%0b/%0d exp=1/1/0", fifo_count, wb_if.wb_valid, wb_if.wb_rd); end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        set_cell(4, 2'd1, 5'd7);
        set_cell(6, 2'd2, 5'd8);
        tick();
        clr_cands();
        rst_n = 1'b0;
        q.delete();
        m_ovf = 0;
        #1;
        n_cmp++; if (fifo_count !== 3'd0 || wb_if.wb_valid !== 1'b0) begin n_err++; $display("FAIL midreset_async got=%0d/%0b exp=0/0", fifo_count, wb_if.wb_valid); end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        retire_entry_t h;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N_CELL; k++) begin
                cand_wb_bus[k*CAND_W +: CAND_W] = {($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                                                   W_pip'($urandom), W_PA_rx'($urandom_range(0, 3) == 0 ? 0 : $urandom)};
                cand_ins_bus[k*W_ident +: W_ident] = ($urandom_range(0, 99) < 25) ? W_ident'(k) : 4'hF;
            end
            ins_req        = 1'($urandom);
            CFI_PC_clear   = ($urandom_range(0, 99) < 5);
            wb_if.wb_ready = ($urandom_range(0, 99) < 60);
            #1;
            n_cmp++; if (addr_insert !== exp_addr() || ins_stall !== exp_stall())
                begin n_err++; $display("FAIL rnd_alloc cyc=%0d got=%0h/%0b exp=%0h/%0b", c, addr_insert, ins_stall, exp_addr(), exp_stall()); end
            tick();
            n_cmp++; if (fifo_count !== CW'(q.size()) || wb_if.wb_valid !== (q.size() != 0) || retire_ovf !== m_ovf)
                begin n_err++; $display("FAIL rnd_state cyc=%0d got=%0d/%0b/%0b exp=%0d/%0b/%0b", c, fifo_count, wb_if.wb_valid, retire_ovf, q.size(), q.size() != 0, m_ovf); end
            if (q.size() != 0) begin
                h = q[0];
                n_cmp++; if (wb_if.wb_pip !== h.pip || wb_if.wb_rd !== h.rd)
                    begin n_err++; $display("FAIL rnd_head cyc=%0d got=%0d/%0d exp=%0d/%0d", c, wb_if.wb_pip, wb_if.wb_rd, h.pip, h.rd); end
            end
        end
        CFI_PC_clear = 1'b0;
        clr_cands();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_single();
        test_multi_capture();
        test_full_backpressure();
        test_flush();
        test_rd_zero();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scb_retire_unit.md
Name: scb_retire_unit

Overview:
- Scoreboard-side controller that sits on the other end of the per-cell scoreboard interface.
- Drives the insert address that selects which cell is allocated.
- Collects each cell's completion candidate ({ready, pip, rd}) into a small in-order retire FIFO.
- Presents one writeback per cycle to the register-file write port over a valid/ready handshake.

Parameters:
- N_CELL, 8, number of scoreboard cells monitored.
- W_ident, 4, cell identifier width; all-ones is the "no cell" code.
- W_pip, 2, pipe tag width.
- W_PA_rx, 5, physical destination register address width.
- FIFO_DEPTH, 4, retire FIFO entries; power of two.
- MAX_CAPT, 2, maximum candidates captured per cycle.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cand_wb_bus  in  N_CELL*(1+W_pip+W_PA_rx)  packed per-cell candidates; cell k occupies slice k; MSB of each slice = ready.
- cand_ins_bus  in  N_CELL*W_ident  packed per-cell insert candidates: own ident if free, else all-ones.
- ins_req  in  1  issue stage requests allocation this cycle.
- CFI_PC_clear  in  1  control-flow flush.
- addr_insert  out  W_ident  ident of the cell to allocate; all-ones when none.
- ins_stall  out  1  ins_req cannot be granted this cycle.
- wb_valid  out  1  writeback entry available.
- wb_ready  in  1  register-file port accepts.
- wb_pip  out  W_pip  pipe tag of the head entry.
- wb_rd  out  W_PA_rx  destination register of the head entry.
- fifo_count  out  clog2(FIFO_DEPTH)+1  occupancy.
- retire_ovf  out  1  sticky: a ready candidate was dropped.

Behaviour:
- Reset (rst_n low, async): FIFO empty, fifo_count=0, wb_valid=0, retire_ovf=0, read/write pointers 0.
- Allocation path (combinational):
  - addr_insert = minimum over cand_ins_bus when ins_req=1 and the FIFO is not full; otherwise all-ones.
  - ins_stall = ins_req & (min==all-ones | FIFO full | CFI_PC_clear).
  - When CFI_PC_clear=1, addr_insert is forced to all-ones.
- Capture:
  - Each cycle, scan cells from index 0 upward and select up to MAX_CAPT slices with ready=1.
  - The selected {pip, rd} are written at the posedge, lowest index at the lower FIFO slot, so program order is by cell index within a cycle.
  - Ready candidates beyond MAX_CAPT, or beyond free space, are dropped and set retire_ovf at the same edge.
- Space accounting:
  - Free space = FIFO_DEPTH − count + pop.
  - A same-cycle pop frees its slot for that cycle's push.
- Drain:
  - wb_valid = (count != 0), registered-state driven; the head entry drives wb_pip/wb_rd.
  - Pop occurs when wb_valid & wb_ready.
  - wb_pip/wb_rd must hold stable while wb_valid=1 and wb_ready=0.
- Latency: a cell ready at cycle t appears on wb_valid at t+1 when the FIFO was empty.
- Pointers wrap modulo FIFO_DEPTH. count = count + push − pop, range 0..FIFO_DEPTH, never exceeded.
- CFI_PC_clear=1 at an edge:
  - FIFO flushed to empty; no capture and no pop that edge.
  - wb_valid=0 the following cycle.
  - retire_ovf unaffected.
- retire_ovf is cleared only by rst_n.
- Reset asserted mid-operation discards all entries immediately.

Optional Feature:
- Macro SCB_RD_ZERO_FILTER_EN.
- Defined: ready candidates with rd==0 are treated as retired without a FIFO push. They consume no capture slot and cannot cause overflow.
- Undefined: rd==0 candidates are captured and written back like any other.

Decomposition:
- Package scb_pkg holds:
  - W_ident, W_pip, W_PA_rx.
  - UNUSED_CD (all-ones).
  - Candidate field offsets (READY_BIT, PIP_LSB, RD_LSB) and the candidate width.
  - The retire-entry struct {pip, rd}.
- Sub-module scb_retire_fifo: multi-push (0..MAX_CAPT), single-pop FIFO with count, flush input and async active-low reset.
- The allocation and capture selectors stay in the top module.

Test Plan:
- Reset, then cells 0..7 all free with ins_req=1 -> addr_insert=0; cells 0,1 busy -> addr_insert=2; all busy -> addr_insert=4'hF, ins_stall=1.
- Cell 3 ready {pip=2, rd=9} for one cycle with wb_ready=1 -> next cycle wb_valid=1, wb_pip=2, wb_rd=9; following cycle wb_valid=0.
- Cells 1,5,6 ready in the same cycle -> entries for cells 1 then 5 pushed in order, cell 6 dropped, retire_ovf=1 and stays 1.
- wb_ready=0 while 4 entries are captured -> fifo_count=4, ins_stall=1 on ins_req, head stable; then a pop plus a push in the same cycle -> count stays 4, no overflow.
- 3 entries queued, CFI_PC_clear pulsed with a cell ready -> next cycle fifo_count=0, wb_valid=0, no capture.
- With SCB_RD_ZERO_FILTER_EN, a cell ready with rd=0 -> no push, count unchanged; without the macro -> writeback with wb_rd=0.
